// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: READY/SETTING/PLAY/OVER match flow, scores, countdown and settings menu.
// Optional pause support is compiled in with `define PONG_PAUSE_EN.
module pong_match_ctrl #(
  parameter int NUM_BALLS = 3,
  parameter int SCORE_W   = 4,
  parameter int TIME_W    = 7,
  parameter int SPEED_W   = 4,
  parameter int DEF_WIN   = 5,
  parameter int MAX_WIN   = 15,
  parameter int DEF_SPEED = 2,
  parameter int MAX_SPEED = 8,
  parameter int DEF_TIME  = 60,
  parameter int MAX_TIME  = 90,
  parameter int OVER_HOLD = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enter_pulse,
  input  logic                 up_pulse,
  input  logic                 down_pulse,
  input  logic                 menu_pulse,
  input  logic                 sec_tick,
  input  logic [NUM_BALLS-1:0] miss_left,
  input  logic [NUM_BALLS-1:0] miss_right,
  input  logic                 pause_pulse,
  output logic [1:0]           main_state,
  output logic [1:0]           setting_field,
  output logic [SCORE_W-1:0]   score1,
  output logic [SCORE_W-1:0]   score2,
  output logic [TIME_W-1:0]    seconds,
  output logic [SCORE_W-1:0]   win_score,
  output logic [SPEED_W-1:0]   ball_speed,
  output logic [TIME_W-1:0]    round_time,
  output logic                 new_round,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic                 paused
);
  localparam logic [1:0] READY = 2'd0, SETTING = 2'd1, PLAY = 2'd2, OVER = 2'd3;
  localparam int HW = $clog2(OVER_HOLD + 1);
  logic [1:0]         state, state_n, field_n, winner_n, end_winner;
  logic [SCORE_W-1:0] score1_n, score2_n, win_n;
  logic [SPEED_W-1:0] speed_n;
  logic [TIME_W-1:0]  seconds_n, round_time_n;
  logic [HW-1:0]      hold, hold_n;
  logic               new_round_n, paused_n, active, end_hit, up_only, dn_only, hit1, hit2;
  assign main_state = state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= READY;
    else state <= state_n;
  assign end_hit = score1 == win_score || score2 == win_score || seconds == '0;
  always_comb begin
    state_n = state;
    case (state)
      READY:   state_n = enter_pulse ? PLAY : menu_pulse ? SETTING : READY;
      SETTING: state_n = (enter_pulse && setting_field >= 2'd2) ? READY : SETTING;
      PLAY:    state_n = end_hit ? OVER : PLAY;
      OVER:    state_n = (sec_tick && hold == HW'(OVER_HOLD - 1)) ? READY : OVER;
    endcase
  end
  assign active  = state == PLAY && !paused;
  assign up_only = up_pulse && !down_pulse;
  assign dn_only = down_pulse && !up_pulse;
  assign hit1    = active && |miss_right;
  assign hit2    = active && |miss_left;
  // Both-at-limit and timeout-draw outcomes share the tie code.
  assign end_winner = (score1 == win_score && score2 == win_score) ? 2'b11 :
                      (score1 == win_score) ? 2'b01 :
                      (score2 == win_score) ? 2'b10 :
                      (score1 > score2) ? 2'b01 :
                      (score2 > score1) ? 2'b10 : 2'b11;
  always_comb begin
    field_n = state_n != SETTING ? 2'd0 :
              (state == SETTING && enter_pulse) ? setting_field + 2'd1 : setting_field;
    win_n = (state != SETTING || setting_field != 2'd0) ? win_score :
            (up_only && win_score < SCORE_W'(MAX_WIN)) ? win_score + SCORE_W'(1) :
            (dn_only && win_score > SCORE_W'(1)) ? win_score - SCORE_W'(1) : win_score;
    speed_n = (state != SETTING || setting_field != 2'd1) ? ball_speed :
              (up_only && ball_speed < SPEED_W'(MAX_SPEED)) ? ball_speed + SPEED_W'(1) :
              (dn_only && ball_speed > SPEED_W'(1)) ? ball_speed - SPEED_W'(1) : ball_speed;
    round_time_n = (state != SETTING || setting_field < 2'd2) ? round_time :
                   (up_only && round_time < TIME_W'(MAX_TIME)) ? round_time + TIME_W'(10) :
                   (dn_only && round_time > TIME_W'(10)) ? round_time - TIME_W'(10) : round_time;
    score1_n = state_n == READY ? '0 :
               (hit1 && score1 < win_score) ? score1 + SCORE_W'(1) : score1;
    score2_n = state_n == READY ? '0 :
               (hit2 && score2 < win_score) ? score2 + SCORE_W'(1) : score2;
    seconds_n = state_n == READY ? round_time :
                (active && sec_tick && seconds != '0) ? seconds - TIME_W'(1) : seconds;
    new_round_n = (state == READY && enter_pulse) || hit1 || hit2;
    winner_n = (state == READY && state_n == PLAY) ? 2'b00 :
               (state == PLAY && state_n == OVER) ? end_winner : winner;
    hold_n = state != OVER ? '0 :
             !sec_tick ? hold :
             state_n == READY ? '0 : hold + HW'(1);
  end
`ifdef PONG_PAUSE_EN
  assign paused_n = (state == PLAY && state_n == PLAY) ? (!enter_pulse && (paused ^ pause_pulse)) : 1'b0;
`else
  logic unused_pause;
  assign unused_pause = pause_pulse;
  assign paused_n = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      setting_field <= 2'd0;
      score1        <= '0;
      score2        <= '0;
      seconds       <= TIME_W'(DEF_TIME);
      win_score     <= SCORE_W'(DEF_WIN);
      ball_speed    <= SPEED_W'(DEF_SPEED);
      round_time    <= TIME_W'(DEF_TIME);
      new_round     <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 2'b00;
      paused        <= 1'b0;
      hold          <= '0;
    end else begin
      setting_field <= field_n;
      score1        <= score1_n;
      score2        <= score2_n;
      seconds       <= seconds_n;
      win_score     <= win_n;
      ball_speed    <= speed_n;
      round_time    <= round_time_n;
      new_round     <= new_round_n;
      game_over     <= state_n == OVER;
      winner        <= winner_n;
      paused        <= paused_n;
      hold          <= hold_n;
    end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: vector table through a scoreboard queue plus hand sequences for settings, timeout, ties and reset.
module tb_pong_match_ctrl;
  logic clk = 0, reset = 1;
  logic enter_pulse = 0, up_pulse = 0, down_pulse = 0, menu_pulse = 0, sec_tick = 0, pause_pulse = 0;
  logic [2:0] miss_left = 0, miss_right = 0;
  logic [1:0] main_state, setting_field, winner;
  logic [3:0] score1, score2, win_score, ball_speed;
  logic [6:0] seconds, round_time;
  logic new_round, game_over, paused;
  int total = 0, bad = 0;

  pong_match_ctrl dut (
    .clk(clk), .reset(reset), .enter_pulse(enter_pulse), .up_pulse(up_pulse),
    .down_pulse(down_pulse), .menu_pulse(menu_pulse), .sec_tick(sec_tick),
    .miss_left(miss_left), .miss_right(miss_right), .pause_pulse(pause_pulse),
    .main_state(main_state), .setting_field(setting_field), .score1(score1), .score2(score2),
    .seconds(seconds), .win_score(win_score), .ball_speed(ball_speed), .round_time(round_time),
    .new_round(new_round), .game_over(game_over), .winner(winner), .paused(paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, menu, tick;
    logic [2:0] ml, mr;
    int st, s1, s2, sec, nr, go, wn;
  } vec_t;
  vec_t tbl[14];
  vec_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic en, up, dn, menu, tick, input logic [2:0] ml, mr, input logic pp);
    @(negedge clk);
    enter_pulse = en; up_pulse = up; down_pulse = dn; menu_pulse = menu;
    sec_tick = tick; miss_left = ml; miss_right = mr; pause_pulse = pp;
    @(posedge clk);
    #1;
    enter_pulse = 0; up_pulse = 0; down_pulse = 0; menu_pulse = 0;
    sec_tick = 0; miss_left = 0; miss_right = 0; pause_pulse = 0;
  endtask

  task automatic idle(); pulse(0, 0, 0, 0, 0, 3'b0, 3'b0, 0); endtask
  task automatic tick(); pulse(0, 0, 0, 0, 1, 3'b0, 3'b0, 0); endtask
  task automatic enter(); pulse(1, 0, 0, 0, 0, 3'b0, 3'b0, 0); endtask
  task automatic up(); pulse(0, 1, 0, 0, 0, 3'b0, 3'b0, 0); endtask
  task automatic down(); pulse(0, 0, 1, 0, 0, 3'b0, 3'b0, 0); endtask
  task automatic both_miss(); pulse(0, 0, 0, 0, 0, 3'b001, 3'b010, 0); endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"}, main_state, 0);
    chk({tag, " field"}, setting_field, 0);
    chk({tag, " s1"}, score1, 0);
    chk({tag, " s2"}, score2, 0);
    chk({tag, " sec"}, seconds, 60);
    chk({tag, " win"}, win_score, 5);
    chk({tag, " speed"}, ball_speed, 2);
    chk({tag, " rtime"}, round_time, 60);
    chk({tag, " nr"}, new_round, 0);
    chk({tag, " go"}, game_over, 0);
    chk({tag, " winner"}, winner, 0);
    chk({tag, " paused"}, paused, 0);
  endtask

  initial begin
    //             en menu tick ml      mr      st s1 s2 sec nr go wn
    tbl[0]  = '{1, 0, 0, 3'b000, 3'b000, 2, 0, 0, 60, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 3'b000, 3'b000, 2, 0, 0, 60, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 3'b000, 3'b011, 2, 1, 0, 60, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 3'b000, 3'b000, 2, 1, 0, 60, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 3'b000, 3'b011, 2, 2, 0, 60, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 3'b000, 3'b011, 2, 3, 0, 60, 1, 0, 0};
    tbl[6]  = '{0, 0, 1, 3'b000, 3'b011, 2, 4, 0, 59, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 3'b000, 3'b011, 2, 5, 0, 59, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 3'b000, 3'b000, 3, 5, 0, 59, 0, 1, 1};
    tbl[9]  = '{0, 0, 0, 3'b111, 3'b111, 3, 5, 0, 59, 0, 1, 1};
    tbl[10] = '{0, 0, 1, 3'b000, 3'b000, 3, 5, 0, 59, 0, 1, 1};
    tbl[11] = '{0, 0, 1, 3'b000, 3'b000, 3, 5, 0, 59, 0, 1, 1};
    tbl[12] = '{0, 0, 1, 3'b000, 3'b000, 0, 0, 0, 60, 0, 0, 1};
    tbl[13] = '{0, 1, 0, 3'b000, 3'b000, 1, 0, 0, 60, 0, 0, 1};
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 0;
    foreach (tbl[i]) begin
      vec_t e;
      sb.push_back(tbl[i]);
      pulse(tbl[i].en, 0, 0, tbl[i].menu, tbl[i].tick, tbl[i].ml, tbl[i].mr, 0);
      e = sb.pop_front();
      chk($sformatf("v%0d state", i), main_state, e.st);
      chk($sformatf("v%0d s1", i), score1, e.s1);
      chk($sformatf("v%0d s2", i), score2, e.s2);
      chk($sformatf("v%0d sec", i), seconds, e.sec);
      chk($sformatf("v%0d nr", i), new_round, e.nr);
      chk($sformatf("v%0d go", i), game_over, e.go);
      chk($sformatf("v%0d winner", i), winner, e.wn);
    end
    chk("menu field", setting_field, 0);
    for (int i = 0; i < 20; i++) up();
    chk("win max", win_score, 15);
    pulse(0, 1, 1, 0, 0, 3'b0, 3'b0, 0);
    chk("win up+down", win_score, 15);
    for (int i = 0; i < 20; i++) down();
    chk("win min", win_score, 1);
    for (int i = 0; i < 4; i++) up();
    chk("win 5", win_score, 5);
    enter();
    chk("field1", setting_field, 1);
    for (int i = 0; i < 10; i++) up();
    chk("speed max", ball_speed, 8);
    for (int i = 0; i < 10; i++) down();
    chk("speed min", ball_speed, 1);
    up();
    enter();
    chk("field2", setting_field, 2);
    for (int i = 0; i < 7; i++) down();
    chk("time min", round_time, 10);
    for (int i = 0; i < 10; i++) up();
    chk("time max", round_time, 90);
    for (int i = 0; i < 3; i++) down();
    chk("time 60", round_time, 60);
    enter();
    chk("set exit state", main_state, 0);
    chk("set exit field", setting_field, 0);
    chk("set exit sec", seconds, 60);
    chk("speed kept", ball_speed, 2);
    enter();
    chk("to play state", main_state, 2);
    chk("winner cleared", winner, 0);
    both_miss();
    chk("1-1 s1", score1, 1);
    chk("1-1 s2", score2, 1);
    for (int i = 0; i < 60; i++) tick();
    chk("timeout sec", seconds, 0);
    chk("timeout still play", main_state, 2);
    tick();
    chk("timeout state", main_state, 3);
    chk("timeout winner", winner, 3);
    chk("timeout sec held", seconds, 0);
    tick();
    tick();
    chk("hold2 state", main_state, 3);
    tick();
    chk("hold done state", main_state, 0);
    chk("hold done s1", score1, 0);
    chk("hold done s2", score2, 0);
    chk("hold winner kept", winner, 3);
    enter();
    for (int i = 0; i < 4; i++) both_miss();
    chk("4-4 s1", score1, 4);
    chk("4-4 s2", score2, 4);
    chk("4-4 state", main_state, 2);
    both_miss();
    chk("5-5 s1", score1, 5);
    chk("5-5 s2", score2, 5);
    idle();
    chk("5-5 state", main_state, 3);
    chk("5-5 winner", winner, 3);
    chk("5-5 go", game_over, 1);
    @(negedge clk);
    reset = 1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 0;
    enter();
    for (int i = 0; i < 5; i++) pulse(0, 0, 0, 0, 0, 3'b100, 3'b000, 0);
    chk("p2 s2", score2, 5);
    idle();
    chk("p2 winner", winner, 2);
    for (int i = 0; i < 3; i++) tick();
    chk("p2 back ready", main_state, 0);
    pulse(1, 0, 0, 1, 0, 3'b0, 3'b0, 0);
    chk("enter beats menu", main_state, 2);
    pulse(0, 0, 0, 0, 0, 3'b0, 3'b0, 1);
`ifdef PONG_PAUSE_EN
    chk("paused on", paused, 1);
    for (int i = 0; i < 10; i++) tick();
    pulse(0, 0, 0, 0, 0, 3'b001, 3'b001, 0);
    chk("paused sec", seconds, 60);
    chk("paused s1", score1, 0);
    chk("paused s2", score2, 0);
    chk("paused nr", new_round, 0);
    pulse(0, 0, 0, 0, 0, 3'b0, 3'b0, 1);
    chk("paused off", paused, 0);
    tick();
    chk("resume sec", seconds, 59);
`else
    chk("pause ignored", paused, 0);
    tick();
    chk("no-pause sec", seconds, 59);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Parametrised match controller for the Pong design. Owns the READY/SETTING/PLAY/OVER flow, per-player scores, the round countdown, the game-over hold and the runtime settings (win score, ball speed, round time). It generalises the top-level match logic to N balls and adds a real settings menu. Sits between the debounced/one-pulsed buttons and the ball, paddle and pixel blocks.

Parameters:
NUM_BALLS, 3, number of balls; width of the miss vectors
SCORE_W, 4, score and win-score width
TIME_W, 7, seconds counter width
SPEED_W, 4, ball speed width
DEF_WIN, 5, win score after reset; legal range 1..MAX_WIN
MAX_WIN, 15, upper limit for win score; must be <= 2^SCORE_W-1
DEF_SPEED, 2, ball speed after reset; legal range 1..MAX_SPEED
MAX_SPEED, 8, upper limit for ball speed
DEF_TIME, 60, round time after reset, in seconds
MAX_TIME, 90, upper limit for round time; must be a multiple of 10
OVER_HOLD, 3, number of sec_tick pulses spent in OVER before returning to READY

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enter_pulse  in  1  one-cycle start/confirm strobe
up_pulse  in  1  one-cycle strobe: increment the current setting
down_pulse  in  1  one-cycle strobe: decrement the current setting
menu_pulse  in  1  one-cycle strobe: enter SETTING from READY
sec_tick  in  1  one-cycle strobe, 1 Hz
miss_left  in  NUM_BALLS  ball i left the field on the left (point to player 2)
miss_right  in  NUM_BALLS  ball i left the field on the right (point to player 1)
pause_pulse  in  1  pause toggle; used only with PONG_PAUSE_EN
main_state  out  2  encoding: 0 READY, 1 SETTING, 2 PLAY, 3 OVER
setting_field  out  2  encoding: 0 win score, 1 speed, 2 time
score1, score2  out  SCORE_W  player scores
seconds  out  TIME_W  remaining time
win_score  out  SCORE_W  current win-score setting
ball_speed  out  SPEED_W  current ball-speed setting
round_time  out  TIME_W  current round-time setting
new_round  out  1  one-cycle pulse: re-serve the balls
game_over  out  1  high while in OVER
winner  out  2  01 = player 1, 10 = player 2, 11 = tie, 00 = none
paused  out  1  high while the match is paused

Behaviour:
- Reset values: main_state=READY; setting_field=0; scores=0; seconds=DEF_TIME; win_score=DEF_WIN; ball_speed=DEF_SPEED; round_time=DEF_TIME; new_round=0; game_over=0; winner=00; paused=0; hold counter=0. All outputs are registered.
- Reset asserted mid-match returns everything to reset values, including the settings.
- READY:
  - scores=0; seconds=round_time.
  - enter_pulse -> PLAY, and new_round=1 on the following cycle.
  - menu_pulse (without enter_pulse) -> SETTING with setting_field=0.
  - If enter_pulse and menu_pulse arrive together, enter wins.
- SETTING:
  - up_pulse / down_pulse adjust the selected field and saturate at its limits:
    - win score: step 1, range 1..MAX_WIN
    - speed: step 1, range 1..MAX_SPEED
    - time: step 10, range 10..MAX_TIME
  - If up and down arrive together: no change.
  - enter_pulse advances the field 0->1->2; enter on field 2 -> READY with setting_field=0.
- PLAY:
  - sec_tick decrements seconds while seconds>0; seconds never wraps.
  - |miss_right (any bit) -> score1+1. |miss_left (any bit) -> score2+1.
  - At most one point per side per cycle. Left and right misses in the same cycle award both players a point.
  - Any miss -> new_round=1 on the next cycle.
  - Scores saturate at win_score.
  - End of match: a registered check moves to OVER one cycle after score1==win_score, score2==win_score, or seconds==0.
- winner is latched on entry to OVER:
  - exactly one score at win_score -> that player
  - both scores at win_score -> 11
  - timeout: higher score wins; equal scores -> 11
- OVER:
  - game_over=1; misses are ignored.
  - Each sec_tick increments the hold counter. When it reaches OVER_HOLD -> READY, the counter clears, and winner is held until the next PLAY entry.
- Arithmetic is unsigned. Comparisons are done at full width with no wrap.

Optional Feature:
Macro PONG_PAUSE_EN.
- Defined: pause_pulse in PLAY toggles paused. While paused, sec_tick and misses are ignored, and enter_pulse clears the pause. paused is forced to 0 in every other state.
- Undefined: pause_pulse is ignored and paused is tied to 0.

Test Plan:
- reset, enter_pulse -> main_state=2, new_round=1 for exactly one cycle, seconds=60, scores 0/0.
- PLAY, miss_right=3'b011 for one cycle, repeated 5 times -> score1=5, then main_state=3, winner=01, game_over=1.
- menu, up_pulse x20 on field 0 -> win_score=15; down x20 -> 1; enter x3 -> READY, setting_field=0; time field down from 60 x7 -> 10.
- PLAY, 60 sec_ticks at 1-1 -> seconds=0, OVER, winner=11; 3 further sec_ticks -> READY, scores 0/0.
- miss_left and miss_right in the same cycle at 4-4 with win_score=5 -> 5-5, winner=11; reset asserted during OVER -> all reset values, win_score=5.
- With PONG_PAUSE_EN: pause_pulse, then 10 sec_ticks and a miss -> seconds and scores unchanged; pause_pulse again -> counting resumes.
